uart_tx_ctrl: RTL and testbench

- Parametrised UART transmit controller with the FSM, serializer, parity generator and output mux integrated in one block.
- Sits between the TX FIFO/synchroniser and the TX pin, in the TX clock domain.
- CLK runs at the bit rate: one bit per CLK cycle.
- Adds over the previous generation:
  - configurable data width;
  - runtime-selectable even/odd parity;
  - optional second stop bit;
  - back-to-back frames with no idle gap;
  - an accept strobe.

---
 rtl/uart_tx_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, LSB-first serializer, parity generator and line mux.
// One bit per CLK; back-to-back frames are accepted in the final stop bit.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP_2,
  output logic                  DATA_ACK,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_ctrl: DATA_WIDTH must be within 5..9");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_d, busy_d;
  logic                  accept;

  // State, datapath and line registers; reset abandons any frame and idles the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      TX_OUT    <= tx_d;
      BUSY      <= busy_d;
    end
  end

  // Next state, datapath updates and next line value.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    accept = DATA_VALID && RST &&
             (state_q == IDLE || state_q == STOP2 || (state_q == STOP1 && !stop2_q));

    case (state_q)
      IDLE:   state_d = IDLE;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          state_d = par_en_q ? PARITY : STOP1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = shift_q >> 1;
        end
      end
      PARITY: state_d = STOP1;
      STOP1:  state_d = stop2_q ? STOP2 : IDLE;
      STOP2:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accept only fires in IDLE or the final stop bit, so it overrides the frame end.
    if (accept) begin
      state_d   = START;
      shift_d   = P_DATA;
      par_en_d  = PAR_EN;
      par_bit_d = (^P_DATA) ^ PAR_TYP;
      stop2_d   = STOP_2;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase

    busy_d   = (state_d != IDLE);
    DATA_ACK = accept;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected line bits are queued on each observed accept
// and popped by a per-cycle line monitor.
module tb_uart_tx_ctrl;
  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP_2 = 1'b0;
  logic          DATA_ACK, TX_OUT, BUSY;

  int checks = 0;
  int failures = 0;

  logic exp_q[$];
  logic txlog[$];
  logic mon_tx, mon_busy;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP_2(STOP_2),
    .DATA_ACK(DATA_ACK), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Line monitor: a queued bit means the line must carry it with BUSY high, else idle.
  always @(negedge CLK) begin
    if (RST) begin
      if (exp_q.size() > 0) begin
        mon_tx   = exp_q.pop_front();
        mon_busy = 1'b1;
      end else begin
        mon_tx   = 1'b1;
        mon_busy = 1'b0;
      end
      if (BUSY === 1'b1) txlog.push_back(TX_OUT);
      checks++;
      if (TX_OUT !== mon_tx || BUSY !== mon_busy) begin
        failures++;
        $display("FAIL line @%0t: TX_OUT=%b BUSY=%b, required TX_OUT=%b BUSY=%b",
                 $time, TX_OUT, BUSY, mon_tx, mon_busy);
      end
    end
  end

  // Reference frame: start, LSB-first data, optional parity, one or two stops.
  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic s2);
    exp_q.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((^d) ^ pt);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  task automatic drive(input logic dv, input logic [DW-1:0] d, input logic pe,
                       input logic pt, input logic s2);
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    STOP_2     = s2;
  endtask

  // Waits (bounded) until the scoreboard drains, counting acks seen meanwhile.
  task automatic drain(output bit ok, output int acks);
    acks = 0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge CLK);
      #1;
      if (DATA_ACK === 1'b1) acks++;
    end
    ok = (exp_q.size() == 0);
  endtask

  // Sends one frame with a single-cycle DATA_VALID and checks the ack pulse.
  task automatic send_one(input string name, input logic [DW-1:0] d, input logic pe,
                          input logic pt, input logic s2);
    bit ok;
    int acks;
    @(negedge CLK);
    drive(1'b1, d, pe, pt, s2);
    #1;
    checks++;
    if (DATA_ACK !== 1'b1) begin
      failures++;
      $display("FAIL %s ack: DATA_ACK=%b, required 1", name, DATA_ACK);
    end
    if (DATA_ACK === 1'b1) push_frame(d, pe, pt, s2);
    txlog.delete();
    @(negedge CLK);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain(ok, acks);
    checks++;
    if (!ok || acks != 0) begin
      failures++;
      $display("FAIL %s drain: drained=%0d extra_acks=%0d, required 1 and 0", name, ok, acks);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    #12;
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || DATA_ACK !== 1'b0) begin
      failures++;
      $display("FAIL reset: TX_OUT=%b BUSY=%b DATA_ACK=%b, required 1 0 0", TX_OUT, BUSY, DATA_ACK);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_a5();
    logic [10:0] got;
    send_one("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    got = '0;
    for (int i = 0; i < txlog.size() && i < 11; i++) got[10-i] = txlog[i];
    checks++;
    if (txlog.size() != 11 || got !== 11'b01010010101) begin
      failures++;
      $display("FAIL a5 bits: len=%0d bits=%b, required len=11 bits=01010010101", txlog.size(), got);
    end
  endtask

  task automatic test_parity();
    send_one("par_odd", 8'h01, 1'b1, 1'b1, 1'b0);
    checks++;
    if (txlog.size() != 11 || txlog[9] !== 1'b0) begin
      failures++;
      $display("FAIL par_odd bit: len=%0d, required parity 0", txlog.size());
    end
    send_one("par_even", 8'h01, 1'b1, 1'b0, 1'b0);
    checks++;
    if (txlog.size() != 11 || txlog[9] !== 1'b1) begin
      failures++;
      $display("FAIL par_even bit: len=%0d, required parity 1", txlog.size());
    end
  endtask

  task automatic test_stop2();
    logic [10:0] got;
    send_one("stop2", 8'h00, 1'b0, 1'b0, 1'b1);
    got = '1;
    for (int i = 0; i < txlog.size() && i < 11; i++) got[10-i] = txlog[i];
    checks++;
    if (txlog.size() != 11 || got !== 11'b00000000011) begin
      failures++;
      $display("FAIL stop2 bits: len=%0d bits=%b, required len=11 bits=00000000011", txlog.size(), got);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acks;
    logic exp_ack;
    @(negedge CLK);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (DATA_ACK !== 1'b1) begin
      failures++;
      $display("FAIL b2b idle ack: DATA_ACK=%b, required 1", DATA_ACK);
    end
    if (DATA_ACK === 1'b1) push_frame(8'h55, 1'b0, 1'b0, 1'b0);
    // Frame 1 is START + 8 data + STOP1; the tenth cycle is its final stop bit.
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      drive(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
      #1;
      exp_ack = (i == 10);
      checks++;
      if (DATA_ACK !== exp_ack) begin
        failures++;
        $display("FAIL b2b ack cycle %0d: DATA_ACK=%b, required %b", i, DATA_ACK, exp_ack);
      end
      if (DATA_ACK === 1'b1) push_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    end
    @(negedge CLK);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain(ok, acks);
    checks++;
    if (!ok || acks != 0) begin
      failures++;
      $display("FAIL b2b drain: drained=%0d extra_acks=%0d, required 1 and 0", ok, acks);
    end
  endtask

  task automatic test_midframe();
    bit ok;
    int acks;
    @(negedge CLK);
    drive(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    #1;
    if (DATA_ACK === 1'b1) push_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (DATA_ACK !== 1'b1) begin
      failures++;
      $display("FAIL mid ack: DATA_ACK=%b, required 1", DATA_ACK);
    end
    repeat (4) begin
      @(negedge CLK);
      drive(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0);
    end
    // Fifth cycle after accept is DATA bit 3.
    @(negedge CLK);
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if (DATA_ACK !== 1'b0) begin
      failures++;
      $display("FAIL mid ignore: DATA_ACK=%b, required 0", DATA_ACK);
    end
    @(negedge CLK);
    drive(1'b0, 8'h77, 1'b0, 1'b1, 1'b1);
    drain(ok, acks);
    checks++;
    if (!ok || acks != 0) begin
      failures++;
      $display("FAIL mid drain: drained=%0d acks=%0d, required 1 and 0", ok, acks);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    if (DATA_ACK === 1'b1) push_frame(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge CLK);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    // Line is carrying a 0 data bit here; reset must raise it without a clock edge.
    #2 RST = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL async reset: TX_OUT=%b BUSY=%b, required 1 0", TX_OUT, BUSY);
    end
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    send_one("post_reset", 8'h3C, 1'b1, 1'b1, 1'b1);
    checks++;
    if (txlog.size() != 12) begin
      failures++;
      $display("FAIL post_reset length: %0d, required 12", txlog.size());
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_midframe();
    test_async_reset();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
